// File: rtl/rob_multi_commit_pkg.sv
// Shared sizes and helpers for the multi-commit reorder buffer.
// A rob id is the entry index plus one, so id 0 can mean "no entry".
package rob_multi_commit_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned IDX_W     = $clog2(ROB_DEPTH);
  localparam int unsigned ID_W      = IDX_W + 1;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned REG_W     = 5;

  localparam logic [ID_W-1:0] ZERO_ROB = '0;
  localparam logic            TRUE     = 1'b1;
  localparam logic            FALSE    = 1'b0;

  function automatic logic [IDX_W-1:0] id_to_idx(input logic [ID_W-1:0] id);
    return IDX_W'(id - ID_W'(1));
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Head-relative retire scan: picks the in-order run of ready entries,
// stopping after the first retiring entry that carries a redirect.
module rob_commit_select
  import rob_multi_commit_pkg::*;
#(
  parameter int unsigned COMMIT_W = 2
) (
  input  logic [IDX_W-1:0]     head,
  input  logic [ROB_DEPTH-1:0] busy,
  input  logic [ROB_DEPTH-1:0] ready,
  input  logic [ROB_DEPTH-1:0] jump,
  output logic [COMMIT_W-1:0]  retire,
  output logic [ID_W-1:0]      n_retire,
  output logic                 stop_jump,
  output logic [IDX_W-1:0]     jump_idx
);

  logic             alive;
  logic [IDX_W-1:0] idx;

  always_comb begin
    retire    = '0;
    n_retire  = '0;
    stop_jump = FALSE;
    jump_idx  = '0;
    alive     = TRUE;
    idx       = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      idx = head + IDX_W'(i);
      if (alive && busy[idx] && ready[idx]) begin
        retire[i] = TRUE;
        n_retire  = n_retire + ID_W'(1);
        if (jump[idx]) begin
          stop_jump = TRUE;
          jump_idx  = idx;
          alive     = FALSE;
        end
      end else begin
        alive = FALSE;
      end
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer with multi-slot in-order retire, several CDB write-back ports,
// same-cycle CDB bypass on operand query and a registered one-cycle flush.
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter int unsigned NUM_CDB    = 3,
  parameter int unsigned COMMIT_W   = 2,
  parameter int unsigned FULL_SLACK = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       alloc_en,
  input  logic [REG_W-1:0]           alloc_rd,
  output logic [ID_W-1:0]            alloc_id,
  output logic                       full_to_if,
  input  logic [ID_W-1:0]            q1_id,
  input  logic [ID_W-1:0]            q2_id,
  output logic                       q1_ready,
  output logic                       q2_ready,
  output logic [DATA_W-1:0]          q1_data,
  output logic [DATA_W-1:0]          q2_data,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*ID_W-1:0]    cdb_id,
  input  logic [NUM_CDB*DATA_W-1:0]  cdb_data,
  input  logic [ADDR_W-1:0]          cdb_target_pc,
  input  logic                       cdb_jump,
  input  logic [ID_W-1:0]            store_ready_id,
  output logic [COMMIT_W-1:0]        commit_valid,
  output logic [COMMIT_W*REG_W-1:0]  commit_rd,
  output logic [COMMIT_W*ID_W-1:0]   commit_id,
  output logic [COMMIT_W*DATA_W-1:0] commit_data,
  output logic                       flush,
  output logic [ADDR_W-1:0]          flush_pc
);

  logic [ROB_DEPTH-1:0] busy_q, busy_d, ready_q, ready_d, jump_q, jump_d;
  logic [REG_W-1:0]     rd_q     [ROB_DEPTH];
  logic [REG_W-1:0]     rd_d     [ROB_DEPTH];
  logic [DATA_W-1:0]    data_q   [ROB_DEPTH];
  logic [DATA_W-1:0]    data_d   [ROB_DEPTH];
  logic [ADDR_W-1:0]    target_q [ROB_DEPTH];
  logic [ADDR_W-1:0]    target_d [ROB_DEPTH];
  logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [ID_W-1:0]      count_q, count_d;

  logic [COMMIT_W-1:0]        cv_q, cv_d;
  logic [COMMIT_W*REG_W-1:0]  crd_q, crd_d;
  logic [COMMIT_W*ID_W-1:0]   cid_q, cid_d;
  logic [COMMIT_W*DATA_W-1:0] cdata_q, cdata_d;
  logic                       flush_q, flush_d;
  logic [ADDR_W-1:0]          flush_pc_q, flush_pc_d;

  logic [COMMIT_W-1:0] retire;
  logic [ID_W-1:0]     n_retire;
  logic                stop_jump, alloc_ok;
  logic [IDX_W-1:0]    jump_idx, widx, cidx, q1_idx, q2_idx;

  rob_commit_select #(
    .COMMIT_W (COMMIT_W)
  ) u_select (
    .head      (head_q),
    .busy      (busy_q),
    .ready     (ready_q),
    .jump      (jump_q),
    .retire    (retire),
    .n_retire  (n_retire),
    .stop_jump (stop_jump),
    .jump_idx  (jump_idx)
  );

  assign alloc_id   = ID_W'(tail_q) + ID_W'(1);
  assign full_to_if = (ID_W'(ROB_DEPTH) - count_q) < ID_W'(FULL_SLACK);
  assign alloc_ok   = alloc_en && (count_q != ID_W'(ROB_DEPTH));

  // Lowest CDB port wins, so scan from the top and let port 0 overwrite last.
  always_comb begin
    q1_idx   = id_to_idx(q1_id);
    q2_idx   = id_to_idx(q2_id);
    q1_ready = FALSE;
    q2_ready = FALSE;
    q1_data  = '0;
    q2_data  = '0;
    if (q1_id != ZERO_ROB && ready_q[q1_idx]) begin
      q1_ready = TRUE;
      q1_data  = data_q[q1_idx];
    end
    if (q2_id != ZERO_ROB && ready_q[q2_idx]) begin
      q2_ready = TRUE;
      q2_data  = data_q[q2_idx];
    end
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (q1_id != ZERO_ROB && cdb_valid[k] && cdb_id[k*ID_W +: ID_W] == q1_id) begin
        q1_ready = TRUE;
        q1_data  = cdb_data[k*DATA_W +: DATA_W];
      end
      if (q2_id != ZERO_ROB && cdb_valid[k] && cdb_id[k*ID_W +: ID_W] == q2_id) begin
        q2_ready = TRUE;
        q2_data  = cdb_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    busy_d     = busy_q;
    ready_d    = ready_q;
    jump_d     = jump_q;
    rd_d       = rd_q;
    data_d     = data_q;
    target_d   = target_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    cv_d       = '0;
    crd_d      = '0;
    cid_d      = '0;
    cdata_d    = '0;
    flush_d    = FALSE;
    flush_pc_d = flush_pc_q;
    widx       = '0;
    cidx       = '0;
    if (!rdy) begin
      // State held; retire/flush pulses drop so nothing is reported twice.
    end else if (flush_q) begin
      busy_d  = '0;
      ready_d = '0;
      jump_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        widx = id_to_idx(cdb_id[k*ID_W +: ID_W]);
        if (cdb_valid[k] && cdb_id[k*ID_W +: ID_W] != ZERO_ROB && busy_q[widx]) begin
          ready_d[widx] = TRUE;
          data_d[widx]  = cdb_data[k*DATA_W +: DATA_W];
          if (k == 0) begin
            target_d[widx] = cdb_target_pc;
            jump_d[widx]   = cdb_jump;
          end
        end
      end
      if (store_ready_id != ZERO_ROB && busy_q[id_to_idx(store_ready_id)]) begin
        ready_d[id_to_idx(store_ready_id)] = TRUE;
      end
      for (int i = 0; i < COMMIT_W; i++) begin
        if (retire[i]) begin
          cidx                         = head_q + IDX_W'(i);
          busy_d[cidx]                 = FALSE;
          ready_d[cidx]                = FALSE;
          jump_d[cidx]                 = FALSE;
          cv_d[i]                      = TRUE;
          crd_d[i*REG_W +: REG_W]      = rd_q[cidx];
          cid_d[i*ID_W +: ID_W]        = ID_W'(cidx) + ID_W'(1);
          cdata_d[i*DATA_W +: DATA_W]  = data_q[cidx];
        end
      end
      if (stop_jump) begin
        flush_d    = TRUE;
        flush_pc_d = target_q[jump_idx];
      end
      head_d = head_q + IDX_W'(n_retire);
      if (alloc_ok) begin
        busy_d[tail_q]   = TRUE;
        ready_d[tail_q]  = FALSE;
        jump_d[tail_q]   = FALSE;
        rd_d[tail_q]     = alloc_rd;
        data_d[tail_q]   = '0;
        target_d[tail_q] = '0;
        tail_d           = tail_q + IDX_W'(1);
      end
      count_d = count_q + ID_W'(alloc_ok) - n_retire;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      ready_q    <= '0;
      jump_q     <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rd_q[i]     <= '0;
        data_q[i]   <= '0;
        target_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cv_q       <= '0;
      crd_q      <= '0;
      cid_q      <= '0;
      cdata_q    <= '0;
      flush_q    <= FALSE;
      flush_pc_q <= '0;
    end else begin
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      jump_q     <= jump_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      target_q   <= target_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      cv_q       <= cv_d;
      crd_q      <= crd_d;
      cid_q      <= cid_d;
      cdata_q    <= cdata_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  assign commit_valid = cv_q;
  assign commit_rd    = crd_q;
  assign commit_id    = cid_q;
  assign commit_data  = cdata_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

  alloc_not_full: assert property (@(posedge clk) disable iff (!rst_n)
    (rdy && !flush_q && alloc_en) |-> (count_q != ID_W'(ROB_DEPTH)));

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit: reset, dual retire, stall, flush, wrap, bypass.
module tb_rob_multi_commit;

  localparam int ID_W     = 5;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int NUM_CDB  = 3;
  localparam int COMMIT_W = 2;

  logic                       clk = 1'b0;
  logic                       rst_n, rdy, alloc_en;
  logic [REG_W-1:0]           alloc_rd;
  logic [ID_W-1:0]            alloc_id;
  logic                       full_to_if;
  logic [ID_W-1:0]            q1_id, q2_id;
  logic                       q1_ready, q2_ready;
  logic [DATA_W-1:0]          q1_data, q2_data;
  logic [NUM_CDB-1:0]         cdb_valid;
  logic [NUM_CDB*ID_W-1:0]    cdb_id;
  logic [NUM_CDB*DATA_W-1:0]  cdb_data;
  logic [31:0]                cdb_target_pc;
  logic                       cdb_jump;
  logic [ID_W-1:0]            store_ready_id;
  logic [COMMIT_W-1:0]        commit_valid;
  logic [COMMIT_W*REG_W-1:0]  commit_rd;
  logic [COMMIT_W*ID_W-1:0]   commit_id;
  logic [COMMIT_W*DATA_W-1:0] commit_data;
  logic                       flush;
  logic [31:0]                flush_pc;

  int checks = 0;
  int errors = 0;

  rob_multi_commit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .alloc_en       (alloc_en),
    .alloc_rd       (alloc_rd),
    .alloc_id       (alloc_id),
    .full_to_if     (full_to_if),
    .q1_id          (q1_id),
    .q2_id          (q2_id),
    .q1_ready       (q1_ready),
    .q2_ready       (q2_ready),
    .q1_data        (q1_data),
    .q2_data        (q2_data),
    .cdb_valid      (cdb_valid),
    .cdb_id         (cdb_id),
    .cdb_data       (cdb_data),
    .cdb_target_pc  (cdb_target_pc),
    .cdb_jump       (cdb_jump),
    .store_ready_id (store_ready_id),
    .commit_valid   (commit_valid),
    .commit_rd      (commit_rd),
    .commit_id      (commit_id),
    .commit_data    (commit_data),
    .flush          (flush),
    .flush_pc       (flush_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cdb();
    cdb_valid      = '0;
    cdb_id         = '0;
    cdb_data       = '0;
    cdb_target_pc  = '0;
    cdb_jump       = 1'b0;
    store_ready_id = '0;
  endtask

  task automatic set_cdb(input int port, input int id, input logic [31:0] data);
    cdb_valid[port]             = 1'b1;
    cdb_id[port*ID_W +: ID_W]   = 5'(id);
    cdb_data[port*DATA_W +: 32] = data;
  endtask

  task automatic alloc(input int rd);
    alloc_en = 1'b1;
    alloc_rd = 5'(rd);
    tick();
    alloc_en = 1'b0;
  endtask

  task automatic do_reset();
    clear_cdb();
    rdy      = 1'b1;
    alloc_en = 1'b0;
    alloc_rd = '0;
    q1_id    = '0;
    q2_id    = '0;
    rst_n    = 1'b0;
    tick();
    rst_n    = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (alloc_id !== 5'd1) begin errors++; $display("FAIL reset_alloc_id got %0d want 1", alloc_id); end
    checks++; if (full_to_if !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full_to_if); end
    for (int i = 0; i < 5; i++) alloc(i + 1);
    checks++; if (alloc_id !== 5'd6) begin errors++; $display("FAIL five_alloc_id got %0d want 6", alloc_id); end
    rst_n = 1'b0;
    #1;
    checks++; if (alloc_id !== 5'd1) begin errors++; $display("FAIL async_reset_alloc_id got %0d want 1", alloc_id); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL reset_commit_valid got %b want 00", commit_valid); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b want 0", flush); end
    checks++; if (alloc_id !== 5'd1) begin errors++; $display("FAIL post_reset_alloc_id got %0d want 1", alloc_id); end
  endtask

  task automatic test_dual_commit();
    do_reset();
    alloc(3);
    alloc(4);
    set_cdb(0, 1, 32'h11);
    set_cdb(1, 2, 32'h22);
    tick();
    clear_cdb();
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL dual_early got %b want 00", commit_valid); end
    tick();
    checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL dual_valid got %b want 11", commit_valid); end
    checks++; if (commit_rd !== {5'd4, 5'd3}) begin errors++; $display("FAIL dual_rd got %h want %h", commit_rd, {5'd4, 5'd3}); end
    checks++; if (commit_id !== {5'd2, 5'd1}) begin errors++; $display("FAIL dual_id got %h want %h", commit_id, {5'd2, 5'd1}); end
    checks++; if (commit_data !== {32'h22, 32'h11}) begin errors++; $display("FAIL dual_data got %h want %h", commit_data, {32'h22, 32'h11}); end
    // Head must now sit at id 3: a new entry retires alone in slot 0.
    alloc(8);
    set_cdb(0, 3, 32'h33);
    tick();
    clear_cdb();
    tick();
    checks++; if (commit_valid !== 2'b01) begin errors++; $display("FAIL head_adv_valid got %b want 01", commit_valid); end
    checks++; if (commit_id[4:0] !== 5'd3) begin errors++; $display("FAIL head_adv_id got %0d want 3", commit_id[4:0]); end
    checks++; if (commit_data[31:0] !== 32'h33) begin errors++; $display("FAIL head_adv_data got %h want 33", commit_data[31:0]); end
  endtask

  task automatic test_stall();
    do_reset();
    alloc(1);
    alloc(2);
    alloc(3);
    set_cdb(1, 2, 32'hB2);
    set_cdb(2, 3, 32'hC3);
    tick();
    clear_cdb();
    tick();
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL stall_valid got %b want 00", commit_valid); end
    set_cdb(0, 1, 32'hA1);
    tick();
    clear_cdb();
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL stall_release_early got %b want 00", commit_valid); end
    tick();
    checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL stall_first_valid got %b want 11", commit_valid); end
    checks++; if (commit_id !== {5'd2, 5'd1}) begin errors++; $display("FAIL stall_first_id got %h want %h", commit_id, {5'd2, 5'd1}); end
    checks++; if (commit_data !== {32'hB2, 32'hA1}) begin errors++; $display("FAIL stall_first_data got %h want %h", commit_data, {32'hB2, 32'hA1}); end
    tick();
    checks++; if (commit_valid !== 2'b01) begin errors++; $display("FAIL stall_second_valid got %b want 01", commit_valid); end
    checks++; if (commit_id[4:0] !== 5'd3) begin errors++; $display("FAIL stall_second_id got %0d want 3", commit_id[4:0]); end
    checks++; if (commit_data[31:0] !== 32'hC3) begin errors++; $display("FAIL stall_second_data got %h want c3", commit_data[31:0]); end
    tick();
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL stall_drained got %b want 00", commit_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc(0);
    alloc(7);
    set_cdb(0, 1, 32'h0);
    cdb_target_pc = 32'h100;
    cdb_jump      = 1'b1;
    set_cdb(1, 2, 32'h77);
    tick();
    clear_cdb();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_early got %0b want 0", flush); end
    tick();
    checks++; if (commit_valid !== 2'b01) begin errors++; $display("FAIL flush_commit_valid got %b want 01", commit_valid); end
    checks++; if (commit_id[4:0] !== 5'd1) begin errors++; $display("FAIL flush_commit_id got %0d want 1", commit_id[4:0]); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL flush_pulse got %0b want 1", flush); end
    checks++; if (flush_pc !== 32'h100) begin errors++; $display("FAIL flush_pc got %h want 100", flush_pc); end
    alloc_en = 1'b1;
    alloc_rd = 5'd9;
    #1;
    checks++; if (alloc_id !== 5'd3) begin errors++; $display("FAIL flush_cycle_alloc_id got %0d want 3", alloc_id); end
    tick();
    alloc_en = 1'b0;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_end got %0b want 0", flush); end
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL flush_end_commit got %b want 00", commit_valid); end
    checks++; if (alloc_id !== 5'd1) begin errors++; $display("FAIL flush_cleared_alloc_id got %0d want 1", alloc_id); end
    tick();
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL flush_id2_dropped got %b want 00", commit_valid); end
  endtask

  task automatic test_wrap();
    int exp_id;
    int got;
    do_reset();
    for (int i = 0; i < 14; i++) alloc(i + 1);
    checks++; if (alloc_id !== 5'd15) begin errors++; $display("FAIL wrap_fill_id got %0d want 15", alloc_id); end
    checks++; if (full_to_if !== 1'b0) begin errors++; $display("FAIL wrap_free2_full got %0b want 0", full_to_if); end
    set_cdb(0, 1, 32'h101);
    set_cdb(1, 2, 32'h102);
    set_cdb(2, 3, 32'h103);
    alloc_en = 1'b1;
    alloc_rd = 5'd15;
    tick();
    clear_cdb();
    alloc_rd = 5'd16;
    checks++; if (full_to_if !== 1'b1) begin errors++; $display("FAIL wrap_free1_full got %0b want 1", full_to_if); end
    checks++; if (alloc_id !== 5'd16) begin errors++; $display("FAIL wrap_id16 got %0d want 16", alloc_id); end
    tick();
    alloc_rd = 5'd1;
    checks++; if (commit_id !== {5'd2, 5'd1} || commit_valid !== 2'b11) begin errors++; $display("FAIL wrap_retire12 got %b/%h want 11/%h", commit_valid, commit_id, {5'd2, 5'd1}); end
    checks++; if (alloc_id !== 5'd1) begin errors++; $display("FAIL wrap_tail_wrapped got %0d want 1", alloc_id); end
    checks++; if (full_to_if !== 1'b0) begin errors++; $display("FAIL wrap_after_retire_full got %0b want 0", full_to_if); end
    tick();
    alloc_en = 1'b0;
    checks++; if (commit_valid !== 2'b01 || commit_data[31:0] !== 32'h103) begin errors++; $display("FAIL wrap_retire3 got %b/%h want 01/103", commit_valid, commit_data[31:0]); end
    checks++; if (alloc_id !== 5'd2) begin errors++; $display("FAIL wrap_alloc_id2 got %0d want 2", alloc_id); end
    // Drain ids 4..16 then the wrapped id 1, three CDB writes per cycle.
    exp_id = 4;
    got    = 0;
    for (int c = 0; c < 30 && got < 14; c++) begin
      for (int p = 0; p < 3; p++) begin
        int n;
        int id;
        n = c * 3 + p;
        if (n < 14) begin
          id = (n < 13) ? n + 4 : 1;
          set_cdb(p, id, 32'h200 + 32'(id));
        end
      end
      tick();
      clear_cdb();
      checks++; if (commit_valid === 2'b10) begin errors++; $display("FAIL wrap_order_gap got %b want 01 or 11", commit_valid); end
      for (int s = 0; s < 2; s++) begin
        if (commit_valid[s]) begin
          checks++; if (commit_id[s*ID_W +: ID_W] !== 5'(exp_id)) begin errors++; $display("FAIL wrap_order_id got %0d want %0d", commit_id[s*ID_W +: ID_W], exp_id); end
          checks++; if (commit_data[s*DATA_W +: DATA_W] !== 32'h200 + 32'(exp_id)) begin errors++; $display("FAIL wrap_order_data got %h want %h", commit_data[s*DATA_W +: DATA_W], 32'h200 + 32'(exp_id)); end
          got++;
          exp_id = (exp_id == 16) ? 1 : exp_id + 1;
        end
      end
    end
    checks++; if (got != 14) begin errors++; $display("FAIL wrap_drain_count got %0d want 14", got); end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 5; i++) alloc(i + 1);
    q1_id = 5'd5;
    #1;
    checks++; if (q1_ready !== 1'b0 || q1_data !== 32'h0) begin errors++; $display("FAIL bypass_not_ready got %0b/%h want 0/0", q1_ready, q1_data); end
    set_cdb(2, 5, 32'hAB);
    #1;
    checks++; if (q1_ready !== 1'b1 || q1_data !== 32'hAB) begin errors++; $display("FAIL bypass_cdb2 got %0b/%h want 1/ab", q1_ready, q1_data); end
    set_cdb(0, 5, 32'hCD);
    q2_id = 5'd5;
    #1;
    checks++; if (q2_ready !== 1'b1 || q2_data !== 32'hCD) begin errors++; $display("FAIL bypass_lowest_port got %0b/%h want 1/cd", q2_ready, q2_data); end
    tick();
    clear_cdb();
    q2_id = 5'd4;
    #1;
    checks++; if (q1_ready !== 1'b1 || q1_data !== 32'hCD) begin errors++; $display("FAIL bypass_stored got %0b/%h want 1/cd", q1_ready, q1_data); end
    checks++; if (q2_ready !== 1'b0 || q2_data !== 32'h0) begin errors++; $display("FAIL query_id4_idle got %0b/%h want 0/0", q2_ready, q2_data); end
    store_ready_id = 5'd4;
    tick();
    clear_cdb();
    checks++; if (q2_ready !== 1'b1 || q2_data !== 32'h0) begin errors++; $display("FAIL store_ready got %0b/%h want 1/0", q2_ready, q2_data); end
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL bypass_no_commit got %b want 00", commit_valid); end
  endtask

  initial begin
    test_reset();
    test_dual_commit();
    test_stall();
    test_flush();
    test_wrap();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
